// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, tag-word bit positions, controller state
// encoding and the line word-merge helper used by dcache_ctrl.
package dcache_pkg;

  localparam int TAG_W      = 23;
  localparam int IDX_W      = 4;
  localparam int OFF_W      = 5;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 256;
  localparam int SRAM_TAG_W = 25;
  localparam int VALID_BIT  = 24;
  localparam int DIRTY_BIT  = 23;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

  // Replace one 32-bit word of a cache line, leaving the other seven intact.
  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [2:0]        sel,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] res;
    res = line;
    res[sel*WORD_W +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, write-allocate data-cache controller.
// The tag/data SRAM lives in the parent; this block only looks it up, merges
// store data into hit lines, and sequences write-back/refill with memory.
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   cpu_addr_i/cpu_data_i/cpu_Mem*_i    CPU request (tag [31:9], index [8:5], offset [4:0])
//   cpu_data_o, cpu_stall_o             load data, stall (hold request while high)
//   mem_*_o, mem_data_i, mem_ack_i      registered line-level memory port
//   sram_*_o, sram_*_i                  lookup/write port of the external tag/data SRAM
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [WORD_W-1:0]     cpu_data_i,
  input  logic                  cpu_MemRead_i,
  input  logic                  cpu_MemWrite_i,
  output logic [WORD_W-1:0]     cpu_data_o,
  output logic                  cpu_stall_o,
  output logic [31:0]           mem_addr_o,
  output logic [LINE_W-1:0]     mem_data_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  input  logic [LINE_W-1:0]     mem_data_i,
  input  logic                  mem_ack_i,
  output logic [IDX_W-1:0]      sram_addr_o,
  output logic [SRAM_TAG_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0]     sram_data_o,
  output logic                  sram_enable_o,
  output logic                  sram_write_o,
  input  logic [SRAM_TAG_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0]     sram_data_i,
  input  logic                  sram_hit_i
);

  state_t            state, state_next;
  logic              req;
  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        word_sel;
  logic              victim_dirty;
  logic              mem_enable_next, mem_write_next;
  logic [31:0]       mem_addr_next;
  logic [LINE_W-1:0] mem_data_next;
  logic              unused_byte_offset;

  // Both strobes high is a write: only the write strobe decides the access type.
  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign cpu_tag      = cpu_addr_i[31:9];
  assign idx          = cpu_addr_i[8:5];
  assign word_sel     = cpu_addr_i[4:2];
  assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];
  assign unused_byte_offset = ^cpu_addr_i[1:0];

  assign sram_enable_o = req;
  assign sram_addr_o   = idx;
  assign cpu_data_o    = sram_data_i[word_sel*WORD_W +: WORD_W];
  assign cpu_stall_o   = req & (~sram_hit_i | (state != IDLE));

  // NOTE: the SRAM array is outside this block and is deliberately not
  // cleared on reset; only the FSM and the registered memory port are.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational block.
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state        <= state_next;
      mem_enable_o <= mem_enable_next;
      mem_write_o  <= mem_write_next;
      mem_addr_o   <= mem_addr_next;
      mem_data_o   <= mem_data_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next      = state;
    mem_enable_next = mem_enable_o;
    mem_write_next  = mem_write_o;
    mem_addr_next   = mem_addr_o;
    mem_data_next   = mem_data_o;
    sram_write_o    = 1'b0;
    sram_tag_o      = {1'b1, 1'b0, cpu_tag};
    sram_data_o     = merge_word(sram_data_i, word_sel, cpu_data_i);

    unique case (state)
      IDLE: begin
        if (req && !sram_hit_i) begin
          state_next = MISS;
        end else if (req && cpu_MemWrite_i) begin
          sram_write_o          = 1'b1;
          sram_tag_o[DIRTY_BIT] = 1'b1;
        end
      end

      MISS: begin
        mem_enable_next = 1'b1;
        if (victim_dirty) begin
          mem_write_next = 1'b1;
          mem_addr_next  = {sram_tag_i[TAG_W-1:0], idx, {OFF_W{1'b0}}};
          mem_data_next  = sram_data_i;
          state_next     = WRITEBACK;
        end else begin
          mem_write_next = 1'b0;
          mem_addr_next  = {cpu_tag, idx, {OFF_W{1'b0}}};
          state_next     = READMISS;
        end
      end

      WRITEBACK: begin
        // Victim is safely in memory: turn the port straight into the refill read.
        if (mem_ack_i) begin
          mem_write_next = 1'b0;
          mem_addr_next  = {cpu_tag, idx, {OFF_W{1'b0}}};
          state_next     = READMISS;
        end
      end

      READMISS: begin
        if (mem_ack_i) begin
          mem_enable_next = 1'b0;
          sram_write_o    = 1'b1;
          sram_data_o     = mem_data_i;
          state_next      = READMISSOK;
        end
      end

      // One bubble so the SRAM lookup sees the freshly written line.
      READMISSOK: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a 16-set, 2-way LRU
// tag/data SRAM model and a memory model with programmable ack latency.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic [31:0]           cpu_addr_i;
  logic [31:0]           cpu_data_i;
  logic                  cpu_MemRead_i, cpu_MemWrite_i;
  logic [31:0]           cpu_data_o;
  logic                  cpu_stall_o;
  logic [31:0]           mem_addr_o;
  logic [LINE_W-1:0]     mem_data_o;
  logic                  mem_enable_o, mem_write_o;
  logic [LINE_W-1:0]     mem_data_i;
  logic                  mem_ack_i;
  logic [IDX_W-1:0]      sram_addr_o;
  logic [SRAM_TAG_W-1:0] sram_tag_o;
  logic [LINE_W-1:0]     sram_data_o;
  logic                  sram_enable_o, sram_write_o;
  logic [SRAM_TAG_W-1:0] sram_tag_i;
  logic [LINE_W-1:0]     sram_data_i;
  logic                  sram_hit_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory contents: word i of line a is {A5, a[23:0]} + i, except 0x20 word1.
  function automatic logic [31:0] line_word(input logic [31:0] a, input int i);
    if (a == 32'h20 && i == 1) return 32'hDEAD_BEEF;
    return {8'hA5, a[23:0]} + 32'(i);
  endfunction

  function automatic logic [LINE_W-1:0] make_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = line_word(a, i);
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [LINE_W-1:0] l, input int i);
    return l[i*32 +: 32];
  endfunction

  // ---------------- SRAM model: 16 sets x 2 ways, LRU victim ----------------
  logic [SRAM_TAG_W-1:0] tag_mem [16][2];
  logic [LINE_W-1:0]     dat_mem [16][2];
  logic                  lru     [16];
  logic                  hit_way, sel_way;
  int                    sram_wr_count = 0;

  initial begin
    for (int s = 0; s < 16; s++) begin
      lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        tag_mem[s][w] = '0;
        dat_mem[s][w] = '0;
      end
    end
  end

  always_comb begin
    hit_way    = 1'b0;
    sram_hit_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (sram_enable_o && tag_mem[sram_addr_o][w][VALID_BIT] &&
          tag_mem[sram_addr_o][w][TAG_W-1:0] == cpu_addr_i[31:9]) begin
        sram_hit_i = 1'b1;
        hit_way    = w[0];
      end
    end
    sel_way     = sram_hit_i ? hit_way : lru[sram_addr_o];
    sram_tag_i  = tag_mem[sram_addr_o][sel_way];
    sram_data_i = dat_mem[sram_addr_o][sel_way];
  end

  always @(posedge clk) begin
    if (sram_enable_o) begin
      if (sram_write_o) begin
        tag_mem[sram_addr_o][sel_way] <= sram_tag_o;
        dat_mem[sram_addr_o][sel_way] <= sram_data_o;
        lru[sram_addr_o]              <= ~sel_way;
        sram_wr_count++;
      end else if (sram_hit_i) begin
        lru[sram_addr_o] <= ~hit_way;
      end
    end
  end

  // ---------------- memory model: ack in cycle mem_lat of a request ----------------
  int          mem_lat = 0;
  int          mem_cnt = 0;
  logic        model_ack = 1'b0;
  logic        manual_ack = 1'b0;
  int          wr_count = 0, rd_count = 0;
  logic [31:0] wr_addr = '0, rd_addr = '0;
  logic [LINE_W-1:0] wr_data = '0;
  logic [LINE_W-1:0] refill = '0;

  assign mem_ack_i  = model_ack | manual_ack;
  assign mem_data_i = refill;

  always @(negedge clk) begin
    if (mem_enable_o) begin
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        model_ack = 1'b1;
        mem_cnt   = 0;
        if (mem_write_o) begin
          wr_count++;
          wr_addr = mem_addr_o;
          wr_data = mem_data_o;
        end else begin
          rd_count++;
          rd_addr = mem_addr_o;
          refill  = make_line(mem_addr_o);
        end
      end else begin
        model_ack = 1'b0;
      end
    end else begin
      mem_cnt   = 0;
      model_ack = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    cpu_addr_i     = addr;
    cpu_data_i     = data;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  // Issue an access and count stalled cycles until the CPU is released.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data, output int stalls);
    logic done;
    done   = 1'b0;
    stalls = 0;
    drive(rd, wr, addr, data);
    for (int k = 0; k < 300; k++) begin
      sample();
      if (!cpu_stall_o) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    check({tag, "_done"}, LINE_W'(done), LINE_W'(1));
  endtask

  int stalls;
  int wc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    sample();
    check("rst_mem_en",   LINE_W'(mem_enable_o), '0);
    check("rst_mem_wr",   LINE_W'(mem_write_o),  '0);
    check("rst_mem_addr", LINE_W'(mem_addr_o),   '0);
    check("rst_mem_data", mem_data_o,            '0);
    check("rst_stall",    LINE_W'(cpu_stall_o),  '0);
    check("rst_sram_en",  LINE_W'(sram_enable_o),'0);

    // Clean read miss, ack on the 10th READMISS cycle.
    mem_lat = 10;
    run_access("rd24", 1'b1, 1'b0, 32'h0000_0024, '0, stalls);
    check("rd24_stalls", LINE_W'(stalls), LINE_W'(13));
    check("rd24_data",   LINE_W'(cpu_data_o), LINE_W'(32'hDEAD_BEEF));
    check("rd24_nowr",   LINE_W'(wr_count), '0);
    check("rd24_raddr",  LINE_W'(rd_addr), LINE_W'(32'h20));
    drive(1'b0, 1'b0, '0, '0);

    // Write hit: single-cycle SRAM write, dirty set, word1 merged.
    drive(1'b1, 1'b1, 32'h0000_0024, 32'h1234_5678);
    drive(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678);
    wc = sram_wr_count;
    sample();
    check("wr_stall",  LINE_W'(cpu_stall_o), '0);
    check("wr_we",     LINE_W'(sram_write_o), LINE_W'(1));
    check("wr_dirty",  LINE_W'(sram_tag_o[DIRTY_BIT]), LINE_W'(1));
    check("wr_valid",  LINE_W'(sram_tag_o[VALID_BIT]), LINE_W'(1));
    check("wr_word1",  LINE_W'(word_of(sram_data_o, 1)), LINE_W'(32'h1234_5678));
    check("wr_word0",  LINE_W'(word_of(sram_data_o, 0)), LINE_W'(line_word(32'h20, 0)));
    drive(1'b0, 1'b0, '0, '0);
    check("wr_pulse",  LINE_W'(sram_wr_count), LINE_W'(wc + 1));
    drive(1'b1, 1'b0, 32'h0000_0024, '0);
    sample();
    check("wr_rb_stall", LINE_W'(cpu_stall_o), '0);
    check("wr_rb_data",  LINE_W'(cpu_data_o), LINE_W'(32'h1234_5678));
    drive(1'b0, 1'b0, '0, '0);

    // Second tag into set 1: free way, clean refill.
    mem_lat = 3;
    run_access("rd220", 1'b1, 1'b0, 32'h0000_0224, '0, stalls);
    check("rd220_stalls", LINE_W'(stalls), LINE_W'(6));
    check("rd220_nowr",   LINE_W'(wr_count), '0);
    check("rd220_data",   LINE_W'(cpu_data_o), LINE_W'(line_word(32'h220, 1)));
    drive(1'b0, 1'b0, '0, '0);

    // Third tag: evicts the dirty 0x20 line, then refills.
    run_access("rd420", 1'b1, 1'b0, 32'h0000_0424, '0, stalls);
    check("rd420_stalls", LINE_W'(stalls), LINE_W'(9));
    check("wb_count",     LINE_W'(wr_count), LINE_W'(1));
    check("wb_addr",      LINE_W'(wr_addr), LINE_W'(32'h20));
    check("wb_word1",     LINE_W'(word_of(wr_data, 1)), LINE_W'(32'h1234_5678));
    check("wb_word0",     LINE_W'(word_of(wr_data, 0)), LINE_W'(line_word(32'h20, 0)));
    check("rd420_raddr",  LINE_W'(rd_addr), LINE_W'(32'h420));
    check("rd420_data",   LINE_W'(cpu_data_o), LINE_W'(line_word(32'h420, 1)));
    drive(1'b0, 1'b0, '0, '0);

    // Both strobes on a hit: a write, no stall.
    drive(1'b1, 1'b1, 32'h0000_0428, 32'hCAFE_F00D);
    sample();
    check("both_stall", LINE_W'(cpu_stall_o), '0);
    check("both_we",    LINE_W'(sram_write_o), LINE_W'(1));
    check("both_dirty", LINE_W'(sram_tag_o[DIRTY_BIT]), LINE_W'(1));
    check("both_word2", LINE_W'(word_of(sram_data_o, 2)), LINE_W'(32'hCAFE_F00D));
    check("both_word1", LINE_W'(word_of(sram_data_o, 1)), LINE_W'(line_word(32'h420, 1)));
    drive(1'b1, 1'b0, 32'h0000_0428, '0);
    sample();
    check("both_rb", LINE_W'(cpu_data_o), LINE_W'(32'hCAFE_F00D));
    drive(1'b0, 1'b0, '0, '0);

    // Ack on the first READMISS cycle (clean victim: tag 1 way).
    mem_lat = 1;
    run_access("rd620", 1'b1, 1'b0, 32'h0000_0624, '0, stalls);
    check("rd620_stalls", LINE_W'(stalls), LINE_W'(4));
    check("rd620_nowb",   LINE_W'(wr_count), LINE_W'(1));
    check("rd620_data",   LINE_W'(cpu_data_o), LINE_W'(line_word(32'h620, 1)));
    drive(1'b0, 1'b0, '0, '0);

    // Reset during READMISS, then a late ack that must be ignored.
    mem_lat = 0;
    drive(1'b1, 1'b0, 32'h0000_0840, '0);
    for (int k = 0; k < 20; k++) begin
      sample();
      if (mem_enable_o) break;
    end
    check("rm_enter", LINE_W'(mem_enable_o), LINE_W'(1));
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0; cpu_MemRead_i = 1'b0;
    sample();
    check("rm_rst_en",   LINE_W'(mem_enable_o), '0);
    check("rm_rst_wr",   LINE_W'(mem_write_o),  '0);
    check("rm_rst_addr", LINE_W'(mem_addr_o),   '0);
    wc = sram_wr_count;
    @(posedge clk); #1 manual_ack = 1'b1;
    sample();
    check("late_ack_we", LINE_W'(sram_write_o), '0);
    @(posedge clk); #1 manual_ack = 1'b0;
    check("late_ack_cnt", LINE_W'(sram_wr_count), LINE_W'(wc));
    sample();
    check("late_ack_en", LINE_W'(mem_enable_o), '0);
    drive(1'b1, 1'b0, 32'h0000_0420, '0);
    sample();
    check("post_rst_stall", LINE_W'(cpu_stall_o), '0);
    check("post_rst_data",  LINE_W'(cpu_data_o), LINE_W'(line_word(32'h420, 0)));
    drive(1'b0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
